// File: rtl/cray_bank_mem_if.sv
// Request/response bundle for the banked word memory.
// The master drives requests; the slave answers with ready, read data and errors.
interface cray_bank_mem_if #(
    parameter int ADDR_W = 22,
    parameter int DATA_W = 64
);
    logic              i_mem_req;
    logic              i_mem_wr_en;
    logic [ADDR_W-1:0] i_mem_addr;
    logic [DATA_W-1:0] i_mem_wr_data;
    logic              o_mem_ready;
    logic [DATA_W-1:0] o_mem_rd_data;
    logic              o_mem_rd_valid;
    logic              o_wr_err;

    modport master (
        output i_mem_req, i_mem_wr_en, i_mem_addr, i_mem_wr_data,
        input  o_mem_ready, o_mem_rd_data, o_mem_rd_valid, o_wr_err
    );

    modport slave (
        input  i_mem_req, i_mem_wr_en, i_mem_addr, i_mem_wr_data,
        output o_mem_ready, o_mem_rd_data, o_mem_rd_valid, o_wr_err
    );
endinterface

// File: rtl/cray_bank_mem.sv
// Interleaved banked word memory with per-bank busy timers and a fixed-latency read pipe.
// Define CRAY_MEM_WR_PROT_EN to drop (and flag) writes below PROT_TOP.
module cray_bank_mem #(
    parameter int ADDR_W     = 22,
    parameter int DATA_W     = 64,
    parameter int DEPTH_LOG2 = 10,
    parameter int BANKS_LOG2 = 4,
    parameter int BANK_BUSY  = 4,
    parameter int RD_LAT     = 2,
    parameter int PROT_TOP   = 256
) (
    input logic             clk,
    input logic             rst,
    cray_bank_mem_if.slave  m
);
    localparam int NB    = 1 << BANKS_LOG2;
    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [BANKS_LOG2-1:0] bank;
    logic [DEPTH_LOG2-1:0] idx;
    logic                  acc;
    logic                  acc_wr;
    logic                  acc_rd;
    logic                  wr_blk;

    logic [3:0]        cnt_q [NB];
    logic [3:0]        cnt_d [NB];
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [RD_LAT-1:0] vld_q;
    logic [RD_LAT-1:0] vld_d;
    logic [DATA_W-1:0] dat_q [RD_LAT];
    logic [DATA_W-1:0] dat_d [RD_LAT];

    assign bank   = m.i_mem_addr[BANKS_LOG2-1:0];
    assign idx    = m.i_mem_addr[DEPTH_LOG2-1:0];
    assign m.o_mem_ready = !rst && (cnt_q[bank] == 4'd0);
    assign acc    = m.i_mem_req && m.o_mem_ready;
    assign acc_wr = acc && m.i_mem_wr_en;
    assign acc_rd = acc && !m.i_mem_wr_en;

    always_comb begin
        for (int b = 0; b < NB; b++) begin
            cnt_d[b] = cnt_q[b];
            if (acc && (bank == BANKS_LOG2'(b))) begin
                cnt_d[b] = 4'(BANK_BUSY - 1);
            end else if (cnt_q[b] != 4'd0) begin
                cnt_d[b] = cnt_q[b] - 4'd1;
            end
        end
        // Data stages only advance behind a valid so the last stage holds.
        vld_d    = '0;
        vld_d[0] = acc_rd;
        dat_d[0] = acc_rd ? mem_q[idx] : dat_q[0];
        for (int i = 1; i < RD_LAT; i++) begin
            vld_d[i] = vld_q[i-1];
            dat_d[i] = vld_q[i-1] ? dat_q[i-1] : dat_q[i];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int b = 0; b < NB; b++) cnt_q[b] <= '0;
            for (int i = 0; i < RD_LAT; i++) dat_q[i] <= '0;
            vld_q <= '0;
        end else begin
            for (int b = 0; b < NB; b++) cnt_q[b] <= cnt_d[b];
            for (int i = 0; i < RD_LAT; i++) dat_q[i] <= dat_d[i];
            vld_q <= vld_d;
        end
    end

    always_ff @(posedge clk) begin
        if (acc_wr && !wr_blk) begin
            mem_q[idx] <= m.i_mem_wr_data;
        end
    end

    assign m.o_mem_rd_valid = vld_q[RD_LAT-1] && !rst;
    assign m.o_mem_rd_data  = rst ? '0 : dat_q[RD_LAT-1];

`ifdef CRAY_MEM_WR_PROT_EN
    logic err_q;
    logic err_d;

    assign wr_blk = 32'(idx) < 32'(PROT_TOP);
    assign err_d  = acc_wr && wr_blk;

    always_ff @(posedge clk) begin
        if (rst) err_q <= 1'b0;
        else     err_q <= err_d;
    end

    assign m.o_wr_err = err_q && !rst;
`else
    logic unused_prot;
    assign unused_prot = (PROT_TOP != 0);
    assign wr_blk      = 1'b0;
    assign m.o_wr_err  = 1'b0;
`endif

    if (ADDR_W > DEPTH_LOG2) begin : g_hi
        logic unused_hi_addr;
        assign unused_hi_addr = ^m.i_mem_addr[ADDR_W-1:DEPTH_LOG2];
    end
endmodule

// File: tb/tb_cray_bank_mem.sv
// Random and directed traffic for cray_bank_mem, checked against a
// timestamp-based bank/latency model and a plain word array.
module tb_cray_bank_mem;
    localparam int ADDR_W     = 22;
    localparam int DATA_W     = 64;
    localparam int DEPTH_LOG2 = 10;
    localparam int BANKS_LOG2 = 4;
    localparam int BANK_BUSY  = 4;
    localparam int RD_LAT     = 2;
    localparam int PROT_TOP   = 256;
    localparam int DEPTH      = 1 << DEPTH_LOG2;
    localparam int NB         = 1 << BANKS_LOG2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    cray_bank_mem_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    cray_bank_mem #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH_LOG2(DEPTH_LOG2),
        .BANKS_LOG2(BANKS_LOG2), .BANK_BUSY(BANK_BUSY),
        .RD_LAT(RD_LAT), .PROT_TOP(PROT_TOP)
    ) dut (
        .clk(clk),
        .rst(rst),
        .m(bus)
    );

    typedef struct {
        int          due;
        logic [63:0] data;
        bit          known;
    } rd_t;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    logic [63:0] ref_mem [DEPTH];
    bit          ref_known [DEPTH];
    rd_t         exp_q [$];
    int          free_at [NB];
    int          err_due  = -1;
    int          last_acc = 0;
    logic [63:0] last_data = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h cyc=%0d", tag, got, exp, cyc);
        end
    endtask

    function automatic bit prot(input int idx);
`ifdef CRAY_MEM_WR_PROT_EN
        return idx < PROT_TOP;
`else
        return (idx < 0);
`endif
    endfunction

    always @(negedge clk) begin
        bit due;
        if (rst) begin
            chk("rst_valid", {63'd0, bus.o_mem_rd_valid}, 64'd0);
            chk("rst_ready", {63'd0, bus.o_mem_ready}, 64'd0);
            chk("rst_data", bus.o_mem_rd_data, 64'd0);
            chk("rst_err", {63'd0, bus.o_wr_err}, 64'd0);
            last_data = '0;
        end else begin
            due = (exp_q.size() > 0) && (exp_q[0].due == cyc);
            chk("rd_valid", {63'd0, bus.o_mem_rd_valid}, {63'd0, due});
            if (due) begin
                if (exp_q[0].known) begin
                    chk("rd_data", bus.o_mem_rd_data, exp_q[0].data);
                    last_data = exp_q[0].data;
                end else begin
                    last_data = bus.o_mem_rd_data;
                end
                void'(exp_q.pop_front());
            end else begin
                chk("rd_hold", bus.o_mem_rd_data, last_data);
            end
            chk("wr_err", {63'd0, bus.o_wr_err}, {63'd0, cyc == err_due});
        end
    end

    task automatic req(input bit wr, input logic [ADDR_W-1:0] a,
                       input logic [63:0] d);
        int idx;
        int b;
        bit acc;
        idx = int'(a[DEPTH_LOG2-1:0]);
        b   = int'(a[BANKS_LOG2-1:0]);
        acc = 1'b0;
        bus.i_mem_req     = 1'b1;
        bus.i_mem_wr_en   = wr;
        bus.i_mem_addr    = a;
        bus.i_mem_wr_data = d;
        for (int n = 0; n < 40 && !acc; n++) begin
            @(negedge clk);
            chk("ready", {63'd0, bus.o_mem_ready}, {63'd0, cyc >= free_at[b]});
            if (bus.o_mem_ready) begin
                acc      = 1'b1;
                last_acc = cyc;
                free_at[b] = cyc + BANK_BUSY;
                if (wr) begin
                    if (prot(idx)) begin
                        err_due = cyc + 1;
                    end else begin
                        ref_mem[idx]   = d;
                        ref_known[idx] = 1'b1;
                    end
                end else begin
                    exp_q.push_back('{due: cyc + RD_LAT, data: ref_mem[idx],
                                      known: ref_known[idx]});
                end
            end
            @(posedge clk);
            #1;
        end
        if (!acc) chk("stall_timeout", 64'd0, 64'd1);
        bus.i_mem_req = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        bus.i_mem_req = 1'b0;
        exp_q.delete();
        err_due = -1;
        for (int b = 0; b < NB; b++) free_at[b] = 0;
        repeat (n) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        int t0;
        bus.i_mem_req     = 1'b0;
        bus.i_mem_wr_en   = 1'b0;
        bus.i_mem_addr    = '0;
        bus.i_mem_wr_data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            ref_mem[i]   = '0;
            ref_known[i] = 1'b0;
        end
        do_reset(3);

        // Fill every word so later reads have a defined reference.
        t0 = cyc;
        for (int i = 0; i < DEPTH; i++) begin
            req(1'b1, ADDR_W'(i), {$urandom, $urandom});
        end
        chk("fill_no_stall", 64'(last_acc - t0), 64'(DEPTH - 1));

        idle(4);
        req(1'b1, 22'h105, 64'h1234);
        t0 = last_acc;
        req(1'b0, 22'h105, 64'd0);
        chk("bank_holdoff", 64'(last_acc - t0), 64'(BANK_BUSY));

        idle(4);
        t0 = cyc;
        for (int i = 0; i < 16; i++) req(1'b0, 22'h100 + 22'(i), 64'd0);
        chk("interleave_no_stall", 64'(last_acc - t0), 64'd15);

        idle(4);
        req(1'b1, 22'h000400, 64'hAA);
        req(1'b0, 22'h000000, 64'd0);
        idle(RD_LAT + 1);
        chk("wrap_data", last_data, 64'hAA);

        idle(4);
        req(1'b0, 22'h107, 64'd0);
        do_reset(1);
        t0 = cyc;
        req(1'b0, 22'h107, 64'd0);
        chk("post_rst_ready", 64'(last_acc - t0), 64'd0);

`ifdef CRAY_MEM_WR_PROT_EN
        idle(4);
        req(1'b1, 22'h010, 64'hFF);
        req(1'b0, 22'h010, 64'd0);
        req(1'b1, 22'h100, 64'hFF);
        req(1'b0, 22'h100, 64'd0);
        idle(RD_LAT + 1);
        chk("prot_open_data", last_data, 64'hFF);
`endif

        for (int k = 0; k < 400; k++) begin
            logic [ADDR_W-1:0] a;
            a = ADDR_W'($urandom);
            if ($urandom_range(0, 1) == 0) a[BANKS_LOG2-1:0] = BANKS_LOG2'($urandom_range(0, 2));
            req(1'($urandom_range(0, 1)), a, {$urandom, $urandom});
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        end

        for (int n = 0; n < 20 && exp_q.size() > 0; n++) idle(1);
        chk("drain", 64'(exp_q.size()), 64'd0);
        idle(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/cray_bank_mem.md
CRAY_BANK_MEM -- requirements
Module: cray_bank_mem

Interface
REQ-001 Parameter ADDR_W, 22, width of word address.
REQ-002 Parameter DATA_W, 64, word width.
REQ-003 Parameter DEPTH_LOG2, 10, log2 of implemented words; upper address bits ignored, so access wraps.
REQ-004 Parameter BANKS_LOG2, 4, log2 of bank count; bank = address[BANKS_LOG2-1:0].
REQ-005 Parameter BANK_BUSY, 4, cycles a bank stays busy after an accepted access (legal 1..15).
REQ-006 Parameter RD_LAT, 2, cycles from read acceptance to o_mem_rd_valid (legal 1..8).
REQ-007 Parameter PROT_TOP, 256, word addresses below this are write-protected when CRAY_MEM_WR_PROT_EN is defined.
REQ-008 clk  input  1  single clock; all logic on the rising edge.
REQ-009 rst  input  1  reset; synchronous, active-high.
REQ-010 i_mem_req  input  1  request valid.
REQ-011 i_mem_wr_en  input  1  1 = write, 0 = read; qualified by i_mem_req.
REQ-012 i_mem_addr  input  ADDR_W  word address.
REQ-013 i_mem_wr_data  input  DATA_W  write data.
REQ-014 o_mem_ready  output  1  combinational; high when the addressed bank is idle and rst is low.
REQ-015 o_mem_rd_data  output  DATA_W  read data, valid only with o_mem_rd_valid.
REQ-016 o_mem_rd_valid  output  1  one-cycle pulse per accepted read.
REQ-017 o_wr_err  output  1  one-cycle pulse for a dropped protected write (tied 0 without the macro).

Function
REQ-018 A request SHALL be accepted in a cycle where i_mem_req and o_mem_ready are both high; otherwise the requester holds its inputs.
REQ-019 Each bank SHALL have a busy counter, loaded with BANK_BUSY-1 on acceptance and decremented to 0; the bank is idle at 0.
REQ-020 With BANK_BUSY=1 the same bank SHALL accept back-to-back requests.
REQ-021 Requests to different idle banks SHALL be accepted on consecutive cycles without stall.
REQ-022 An accepted write SHALL update the word at address[DEPTH_LOG2-1:0] at that clock edge.
REQ-023 An accepted read SHALL sample the array at the acceptance edge, so it sees all earlier accepted writes.
REQ-024 An accepted read SHALL assert o_mem_rd_valid exactly RD_LAT cycles after acceptance, through an RD_LAT-stage valid/data pipeline.
REQ-025 Read responses SHALL return in acceptance order, with at most one per cycle.
REQ-026 o_mem_rd_data SHALL hold its last value when o_mem_rd_valid is low.

Reset
REQ-027 While rst is high: all bank counters clear to 0, the valid pipeline clears, o_mem_rd_valid=0, o_wr_err=0, o_mem_ready=0, o_mem_rd_data=0.
REQ-028 Reads in flight when rst asserts SHALL be discarded and produce no o_mem_rd_valid.
REQ-029 Array contents SHALL NOT be reset.
REQ-030 The first request SHALL be accepted in the first cycle with rst low.

Configuration
REQ-031 Macro CRAY_MEM_WR_PROT_EN defined: an accepted write with address[DEPTH_LOG2-1:0] < PROT_TOP SHALL NOT modify the array, SHALL pulse o_wr_err the next cycle, and SHALL still occupy the bank for BANK_BUSY cycles.
REQ-032 Macro CRAY_MEM_WR_PROT_EN undefined: all writes modify the array, o_wr_err is constant 0, and PROT_TOP is unused.

Verification
REQ-033 Default parameters: write 0x1234 to address 0x105 (bank 5), then read 0x105 -> read held off 3 cycles (o_mem_ready=0), then accepted; 2 cycles later o_mem_rd_valid=1 and o_mem_rd_data=0x1234.
REQ-034 Reads to addresses 0x100..0x10F on 16 consecutive cycles -> no stalls; 16 consecutive rd_valid pulses with data in address order.
REQ-035 DEPTH_LOG2=10: write 0xAA to address 0x000400, read address 0x000000 -> data 0xAA (wrap-around).
REQ-036 Reset asserted one cycle after a read is accepted -> no rd_valid pulse; after reset, bank is immediately ready.
REQ-037 With CRAY_MEM_WR_PROT_EN: write 0xFF to address 0x010 -> o_wr_err pulses once, read 0x010 returns prior value; write to 0x100 -> no error, read returns 0xFF.
REQ-038 BANK_BUSY=1, RD_LAT=1: alternate write/read to address 0x003 every cycle -> no stalls, each read returns the immediately preceding write's data.
